// File: rtl/robs_control_unit.sv
// robs_control_unit
//   Moore-style sequencer for the signed Robertson's multiplier datapath.
//   It walks the datapath through LOAD, COPY, then WIDTH iterations of
//   TEST / (ADD|SUB) / SHIFT / WRITE, then STORE and DONE. It branches only
//   on the datapath flags zr (multiplier LSB is 0) and zq (counter at 0).
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high reset
//   start  in   begin a multiply; sampled only in IDLE
//   zr     in   current multiplier bit is 0
//   zq     in   iteration counter is 0 (sign iteration)
//   c      out  15-bit datapath control word (registered)
//   busy   out  high in every state except IDLE (registered)
//   done   out  one-cycle pulse in DONE (registered)

module robs_control_unit #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        zr,
    input  logic        zq,
    output logic [14:0] c,
    output logic        busy,
    output logic        done
);

    // The datapath counter reloads to WIDTH-1, so fewer than two bits
    // would leave no add iterations at all.
    if (WIDTH < 2) begin : g_width_check
        $error("robs_control_unit: WIDTH must be at least 2");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_COPY, S_TEST, S_ADD,
        S_SUB, S_SHIFT, S_WRITE, S_STORE, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [14:0] c_q, c_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    // Control word for a state. c13 (counter decrement) in WRITE depends on
    // zq; it is computed while leaving SHIFT, and the counter does not move
    // between SHIFT and WRITE, so the zq seen then equals zq in WRITE.
    function automatic logic [14:0] decode(input state_t s, input logic zq_now);
        logic [14:0] w;
        w = '0;
        case (s)
            S_LOAD:  w = 15'h000F;               // c0 c1 c2 c3, X <- multiplier
            S_COPY:  w = 15'h0300;               // c8 c9, R <- {A, X}
            S_ADD:   w = 15'h0520;               // R-high <- ALU add
            S_SUB:   w = 15'h0120;               // R-high <- ALU subtract
            S_SHIFT: w = 15'h1800;               // arithmetic shift of R
            S_WRITE: w = zq_now ? 15'h0B50 : 15'h2B50;
            S_STORE: w = 15'h4088;               // A <- R-high, X <- R-low
            default: w = '0;                     // IDLE, TEST, DONE
        endcase
        return w;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_COPY;
            S_COPY:  state_d = S_TEST;
            S_TEST: begin
                if (zr)      state_d = S_SHIFT;
                else if (zq) state_d = S_SUB;    // sign bit carries negative weight
                else         state_d = S_ADD;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SUB:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_WRITE;
            S_WRITE: state_d = zq ? S_STORE : S_TEST;
            S_STORE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Outputs are registered: decode the state being entered.
        c_d    = decode(state_d, zq);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c    = c_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_robs_control_unit.sv
// Bench for robs_control_unit: a behavioural Robertson datapath reacts to c
// and produces zr/zq and the product; a cycle monitor checks every control
// word against the state-to-state table, and a scoreboard of expected
// product / latency / ADD and SUB counts is popped on each done.
// Latency is counted in edges: start sampled at edge E0, LOAD seen right
// after E0, DONE seen right after edge E0+3+N, N = 3*WIDTH + popcount.

module tb_robs_control_unit;
    localparam int W = 8;

    localparam logic [14:0] C_LOAD  = 15'h000F;
    localparam logic [14:0] C_COPY  = 15'h0300;
    localparam logic [14:0] C_TEST  = 15'h0000;
    localparam logic [14:0] C_ADD   = 15'h0520;
    localparam logic [14:0] C_SUB   = 15'h0120;
    localparam logic [14:0] C_SHIFT = 15'h1800;
    localparam logic [14:0] C_WRITE = 15'h0B50;
    localparam logic [14:0] C_DEC   = 15'h2000;
    localparam logic [14:0] C_STORE = 15'h4088;

    logic        clk = 1'b0;
    logic        reset, start, zr, zq;
    logic [14:0] c;
    logic        busy, done;

    always #5 clk = ~clk;

    robs_control_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .zr(zr), .zq(zq),
        .c(c), .busy(busy), .done(done)
    );

    // ---------------- behavioural datapath ----------------
    logic [W-1:0]        mplier = '0, mcand = '0;
    logic [W-1:0]        y_r = '0, x_r = '0, a_r = '0, lo_r = '0, shlo_r = '0, cnt_r = '0;
    logic signed [W:0]   hi_r = '0, shhi_r = '0;
    logic signed [W:0]   ysx;

    assign ysx = {y_r[W-1], y_r};
    assign zr  = ~lo_r[0];
    assign zq  = (cnt_r == '0);

    always @(posedge clk) begin
        if (c[0]) y_r <= mcand;
        if (c[2]) a_r <= '0;
        if (c[14]) a_r <= hi_r[W-1:0];
        if (c[3]) x_r <= c[7] ? lo_r : mplier;
        if (c[1]) cnt_r <= W[W-1:0] - 1'b1;
        else if (c[13]) cnt_r <= cnt_r - 1'b1;
        if (c[12]) begin
            if (c[11]) {shhi_r, shlo_r} <= $signed({hi_r, lo_r}) >>> 1;
            else       {shhi_r, shlo_r} <= {hi_r, lo_r} >> 1;
        end
        if (c[8]) begin
            case (c[5:4])
                2'b00: hi_r <= {a_r[W-1], a_r};
                2'b01: hi_r <= shhi_r;
                2'b10: hi_r <= c[10] ? hi_r + ysx : hi_r - ysx;
                default: ;
            endcase
        end
        if (c[9]) lo_r <= c[6] ? shlo_r : x_r;
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        logic [2*W-1:0] prod;
        int             lat;
        int             adds;
        int             subs;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, e0 = 0, n_add = 0, n_sub = 0, n_shift = 0, last_done = -1;
    bit   b2b = 1'b0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {done, busy, c} after an edge, from the word seen before it.
    function automatic logic [16:0] next_obs(input logic [16:0] p, input logic r,
                                              input logic s, input logic fzr, input logic fzq);
        logic [14:0] nc;
        logic        nb, nd;
        nc = '0; nb = 1'b1; nd = 1'b0;
        if (r)          nb = 1'b0;
        else if (p[16]) nb = 1'b0;
        else if (!p[15]) begin
            if (s) nc = C_LOAD; else nb = 1'b0;
        end else begin
            case (p[14:0])
                C_LOAD:          nc = C_COPY;
                C_COPY:          nc = C_TEST;
                C_TEST:          nc = fzr ? C_SHIFT : (fzq ? C_SUB : C_ADD);
                C_ADD, C_SUB:    nc = C_SHIFT;
                C_SHIFT:         nc = fzq ? C_WRITE : (C_WRITE | C_DEC);
                C_WRITE:         nc = C_STORE;
                C_WRITE | C_DEC: nc = C_TEST;
                C_STORE:         nd = 1'b1;
                default:         nc = 15'h7FFF;
            endcase
        end
        return {nd, nb, nc};
    endfunction

    logic [16:0] prev_obs = '0, obs;
    logic        r_e, s_e, zr_e, zq_e;
    exp_t        cur;

    always @(posedge clk) begin
        r_e = reset; s_e = start; zr_e = zr; zq_e = zq;
        cyc++;
        #1;
        obs = {done, busy, c};
        check("ctrl_seq", obs, next_obs(prev_obs, r_e, s_e, zr_e, zq_e));
        prev_obs = obs;
        if (busy && c == C_LOAD) begin
            if (b2b && last_done >= 0) check("b2b_gap", cyc - last_done, 2);
            e0 = cyc; n_add = 0; n_sub = 0; n_shift = 0;
        end
        if (c == C_ADD)   n_add++;
        if (c == C_SUB)   n_sub++;
        if (c == C_SHIFT) n_shift++;
        if (done) begin
            check("done_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                check("latency", cyc - e0, cur.lat);
                check("product", {a_r, x_r}, cur.prod);
                check("add_visits", n_add, cur.adds);
                check("sub_visits", n_sub, cur.subs);
            end
            if (b2b) last_done = cyc;
        end
    end

    task automatic push(input logic [W-1:0] mr, input logic [W-1:0] md, input int lat);
        exp_t e;
        logic signed [2*W-1:0] p;
        p = $signed(mr) * $signed(md);
        e.prod = p;
        e.lat  = lat;
        e.adds = $countones(mr[W-2:0]);
        e.subs = int'(mr[W-1]);
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input logic [W-1:0] mr, input logic [W-1:0] md, input int lat);
        mplier = mr; mcand = md;
        push(mr, md, lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();
    endtask

    initial begin
        int n;
        // Reset held two cycles with start high, then 3 x 5.
        reset = 1'b1; start = 1'b1; mplier = 8'h03; mcand = 8'h05;
        repeat (2) @(negedge clk);
        check("rst_c", c, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        push(8'h03, 8'h05, 29);
        reset = 1'b0;
        @(negedge clk);
        check("load_after_rst", c, C_LOAD);
        start = 1'b0;
        wait_drain();

        run_op(8'hFD, 8'h05, 34);   // -3 x 5
        run_op(8'hFA, 8'hF9, 33);   // -6 x -7

        // Reset in the third SHIFT abandons the operation.
        mplier = 8'h55; mcand = 8'h11;
        push(8'h55, 8'h11, 3 + 3 * W + 4);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n_shift < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("third_shift_seen", c, C_SHIFT);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
        check("mid_rst_c", c, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        repeat (5) @(negedge clk);
        run_op(8'h00, 8'h7F, 27);

        // start held high across two operations.
        mplier = 8'h05; mcand = 8'hF0;
        b2b = 1'b1;
        push(8'h05, 8'hF0, 29);
        push(8'h05, 8'hF0, 29);
        start = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_drained", sb.size(), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        b2b = 1'b0;
        check("b2b_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/robs_control_unit.md
# robs_control_unit

Moore-style sequencer for the signed Robertson's multiplier datapath. It accepts a start request, drives the 15-bit datapath control word `c` through load, iterate (add/subtract, shift, write-back) and store phases, and reports completion. It branches only on the datapath status flags `zr` (multiplier LSB is 0) and `zq` (iteration counter at 0). It sits beside the datapath inside the multiplier top level.

## Interface
- `WIDTH`, default 8: operand width. It must equal the datapath `WIDTH`. The datapath down-counter reloads to `WIDTH-1`.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start`  in  1  request to multiply the operands currently present on the datapath inputs; sampled only in IDLE.
- `zr`  in  1  1 when `r[0]==0`, i.e. the current multiplier bit is 0.
- `zq`  in  1  1 when the iteration counter is 0, i.e. the final (sign) iteration.
- `c`  out  15  datapath control word; bit map under Operation.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE; the product is valid on the datapath output from this cycle until the next LOAD.

## Operation
- **Control bit map:**
  - c0 load Y
  - c1 counter reload (to WIDTH-1)
  - c2 clear A
  - c3 load X
  - c5:4 R-high source (00 A, 01 shifter high, 10 ALU)
  - c6 R-low source (0 X, 1 shifter low)
  - c7 X source (0 multiplier, 1 R-low)
  - c8 load R-high
  - c9 load R-low
  - c10 ALU op (1 add, 0 subtract)
  - c11 shift mode (1 arithmetic)
  - c12 shifter enable
  - c13 counter decrement
  - c14 load A
- **Control-word decode:** `c` is decoded purely from the state register. Any bit not listed for a state is 0.
- **States, asserted bits, and transitions:**
  - IDLE: `c=0`. If `start`, go to LOAD.
  - LOAD: c0, c1, c2, c3 (c7=0). Go to COPY.
  - COPY: c8, c9 (c5:4=00, c6=0), so R = {A, X}. Go to TEST.
  - TEST: no bits asserted. Branch on the flags:
    - `zr=1`: go to SHIFT.
    - `zr=0` and `zq=0`: go to ADD.
    - `zr=0` and `zq=1`: go to SUB.
  - ADD: c5:4=10, c10=1, c8. Go to SHIFT.
  - SUB: c5:4=10, c10=0, c8. Go to SHIFT.
  - SHIFT: c11, c12. Go to WRITE.
  - WRITE: c5:4=01, c6, c8, c9, c11.
    - `zq=1`: go to STORE, with no decrement.
    - `zq=0`: assert c13 and go to TEST.
  - STORE: c14, c3, c7=1, so A = R-high and X = R-low. Go to DONE.
  - DONE: `done=1`. Go to IDLE unconditionally.
- **Iteration count:** exactly WIDTH iterations. Counter values WIDTH-1 down to 1 are add iterations; 0 is the subtract (sign) iteration.
- **Operand ownership:** the controller performs no arithmetic. Operands must be stable from the `start` cycle through LOAD; they are not sampled after LOAD.
- **Operand range:** the `-2^(WIDTH-1) × -2^(WIDTH-1)` case is outside the supported range. The result for that case is unspecified.

## Timing
- **Reset:** `reset` high at any edge puts the controller in IDLE with `c=0`, `busy=0`, `done=0` on the following cycle. This applies mid-operation too; the partial product is abandoned and there is no `done`.
- **Start acceptance:** `start` is ignored when not in IDLE. `start` held high through DONE begins a new operation: DONE→IDLE, then IDLE→LOAD on the next edge.
- **Flag sampling:** `zr` and `zq` are sampled only in TEST (both) and WRITE (`zq`); they are don't-care elsewhere.
- **Iteration length:** 3 cycles when the bit is 0 (TEST, SHIFT, WRITE); 4 cycles when the bit is 1.
- **Latency:**
  - With `start` sampled at edge E0, LOAD occupies cycle E0+1 and DONE occupies cycle E0+3+N.
  - N = 3·WIDTH + popcount(multiplier).
  - For WIDTH=8: minimum at E0+27 (multiplier 0), maximum at E0+35 (multiplier 0xFF).
- **Busy window:** `busy` rises in LOAD and falls in the cycle after DONE.

## Test plan
- **Reset:** hold `reset` 2 cycles with `start=1` → `c=0`, `busy=0`, `done=0`; LOAD is entered the first cycle after reset deasserts.
- **3×5:** multiplier 0x03, multiplicand 0x05, `start` pulse → ADD visited exactly twice, no SUB, `done` at E0+29, product 0x000F.
- **-3×5:** multiplier 0xFD, multiplicand 0x05 → six ADDs, one SUB, `done` at E0+34, product 0xFFF1.
- **-7×-6:** multiplier 0xFA, multiplicand 0xF9 → `done` at E0+33, product 0x002A. Checker confirms every `c` word matches the per-state decode each cycle.
- **Reset mid-operation:** pulse `reset` in the 3rd SHIFT → IDLE next cycle with no `done`. A following 0x00×0x7F run gives `done` at E0+27 and product 0x0000.
- **Back-to-back:** `start` held high continuously → `start` ignored while busy, one `done` per operation, and IDLE lasts exactly one cycle between DONE and the next LOAD.
